reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-read-port register file for the pipeline decode stage, replacing the fixed 32x32, two-port register file. It provides N synchronous read ports, one write port, an optional hardwired-zero register and an optional write-to-read bypass. A built-in scrub sequencer clears every entry after reset or on request, so no initial-block preload is needed. Decode reads and writeback writes both occur on the rising edge of `clk`.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, when 1, entry 0 reads as 0 and ignores writes

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `clr`  in  1  one-cycle pulse that starts a scrub of all entries
- `we`  in  1  write enable
- `waddr`  in  ADDR_W  write address
- `wdata`  in  DATA_W  write data
- `raddr`  in  NUM_RD*ADDR_W  packed read addresses; port k is bits [k*ADDR_W +: ADDR_W]
- `rdata`  out  NUM_RD*DATA_W  packed registered read data; port k is bits [k*DATA_W +: DATA_W]
- `ready`  out  1  1 when the file is in service; 0 during a scrub

## Operation
- States: SCRUB and READY.
- Reset (`reset_n` = 0), asynchronous:
  - state = SCRUB, scrub index = 0
  - all `rdata` = 0, `ready` = 0
  - storage array is not reset directly; the scrub sequencer clears it.
- SCRUB state:
  - Each cycle, write 0 to entry[index], then increment the index.
  - When index = DEPTH-1, write that entry and go to READY.
  - Takes exactly DEPTH cycles.
  - `we` is ignored. `clr` is ignored.
  - Every `rdata` port registers 0.
- READY state:
  - On the rising edge with `we` = 1, entry[waddr] <= wdata.
  - If `ZERO_REG` = 1 and waddr = 0, the write is discarded.
  - Each read port k registers entry[raddr_k] every cycle (no enable).
  - If `ZERO_REG` = 1 and raddr_k = 0, port k registers 0.
  - Any number of ports may read the same address.
- `clr` = 1 in READY:
  - The next state is SCRUB with index 0.
  - A `we` in that same cycle is dropped (clr wins).
- Read-during-write (same edge, raddr_k = waddr, write not discarded): behaviour is set by `REG_FILE_BYPASS_EN`, see Configuration.
- Arithmetic: the scrub index is ADDR_W bits. Its wrap from DEPTH-1 is never used, because the transition to READY happens at DEPTH-1.

## Timing
- Read latency: 1 cycle. An address presented before edge t appears on `rdata` after edge t.
- Write latency: 1 cycle. A write at edge t is visible to a read sampled at edge t+1, regardless of the macro.
- After `reset_n` rises, edges 1..DEPTH perform the scrub. `ready` = 1 after edge DEPTH (32 cycles at the default parameters).
- `ready` falls on the edge that samples `clr` = 1. It rises DEPTH edges later.
- Reset asserted mid-scrub or mid-write: the state machine restarts at SCRUB with index 0 immediately. A partial write is not guaranteed to land.

## Configuration
- Macro `REG_FILE_BYPASS_EN` defined:
  - Read-during-write forwards `wdata` to `rdata` in the same edge.
  - Forwarding is per port and follows the `ZERO_REG` rules.
- Macro undefined:
  - Read-during-write returns the old entry value.
  - The pipeline must then resolve the hazard by forwarding or a stall.

## Structure
- Shared package `reg_file_pkg` holds:
  - default widths `RF_DATA_W` and `RF_ADDR_W`
  - state encoding `RF_SCRUB` = 1'b0, `RF_READY` = 1'b1
  - `RF_MAX_RD` = 4
- One sub-module, `rf_scrub_seq`:
  - owns the state register and index counter
  - outputs `scrub_we`, `scrub_addr` and `ready`
  - the top level muxes these onto the write port.
- Read ports are built with a generate loop over `NUM_RD`.

## Test plan
- Reset release: hold `reset_n` = 0 for 3 cycles, then release. Expect `ready` = 0 for 32 cycles then 1, and all 32 entries read 0.
- Basic write/read: write 0xDEADBEEF to entry 7. One cycle later, read port 0 = 7 and port 1 = 7; both `rdata` ports return 0xDEADBEEF.
- Zero register (`ZERO_REG` = 1): write 0x12345678 to entry 0, then read entry 0. Expect 0.
- Bypass: write 0xA5A5A5A5 to entry 3 while port 1 reads entry 3 on the same edge.
  - With the macro defined, expect 0xA5A5A5A5.
  - With the macro undefined, expect the previous value (0).
- Clear with a concurrent write: in READY, pulse `clr` with `we` = 1 to entry 5 (0x55).
  - `ready` goes low for 32 cycles.
  - Entry 5 then reads 0, and every other entry reads 0.
- Reset mid-scrub: assert `reset_n` = 0 at scrub index 10, then release. `ready` rises a full 32 cycles after the release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
//
// Purpose: shared definitions for the multi-read-port register file used in
//          the pipeline decode stage.
//
// Contents:
//   RF_DATA_W  - default register width in bits
//   RF_ADDR_W  - default address width (depth = 2**RF_ADDR_W)
//   RF_MAX_RD  - largest supported number of read ports
//   rf_state_e - scrub sequencer state encoding (RF_SCRUB / RF_READY)
//   rfDepth()  - helper turning an address width into an entry count
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_MAX_RD = 4;

    // The file is either clearing itself or serving the pipeline.
    typedef enum logic {
        RF_SCRUB = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    function automatic int rfDepth(input int addrW);
        return 1 << addrW;
    endfunction

endpackage : reg_file_pkg

// File: rtl/rf_scrub_seq.sv
// ---------------------------------------------------------------------------
// rf_scrub_seq
//
// Purpose: scrub sequencer for reg_file_mp. Owns the service state and the
//          entry index that walks the storage array writing zeros after
//          reset or on a clear request.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset
//   clr        in   one-cycle request to start a scrub (honoured in READY)
//   scrub_we   out  1 while the sequencer owns the storage write port
//   scrub_addr out  entry being cleared this cycle
//   ready      out  registered: 1 when the file is in service
// ---------------------------------------------------------------------------
module rf_scrub_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    output logic              scrub_we,
    output logic [ADDR_W-1:0] scrub_addr,
    output logic              ready
);

    // Last entry of the array; reaching it ends the scrub, so the index
    // never needs to wrap.
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    rf_state_e         state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic              ready_q;

    // Next scrub index.
    always_comb begin
        idx_d = idx_q + ADDR_W'(1);
    end

    // Service state machine: SCRUB clears one entry per cycle for exactly
    // DEPTH cycles, READY waits for a clear request. ready is kept as its
    // own flop so the output is glitch-free and matches the state exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RF_SCRUB;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == RF_SCRUB) begin
            if (idx_q == LAST_IDX) begin
                state_q <= RF_READY;
                idx_q   <= '0;
                ready_q <= 1'b1;
            end else begin
                idx_q <= idx_d;
            end
        end else begin
            if (clr) begin
                state_q <= RF_SCRUB;
                idx_q   <= '0;
                ready_q <= 1'b0;
            end
        end
    end

    assign scrub_we   = (state_q == RF_SCRUB);
    assign scrub_addr = idx_q;
    assign ready      = ready_q;

endmodule : rf_scrub_seq

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//
// Purpose: parametrised register file for the decode stage with NUM_RD
//          registered read ports, one write port, an optional hardwired-zero
//          entry 0 and a built-in scrub that clears every entry after reset
//          or on a clr pulse.
//
// Build option:
//   REG_FILE_BYPASS_EN - when defined, a read of the entry being written on
//                        the same edge returns the new wdata; otherwise it
//                        returns the old contents.
//
// Ports:
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   clr      in   pulse that starts a scrub (also cancels a same-cycle write)
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata    out  packed registered read data, port k at [k*DATA_W +: DATA_W]
//   ready    out  1 in service, 0 while scrubbing
// ---------------------------------------------------------------------------
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     ready
);

    localparam int DEPTH = rfDepth(ADDR_W);

    logic              scrubWe;
    logic [ADDR_W-1:0] scrubAddr;
    logic              userWr;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;

    logic [DATA_W-1:0] mem_q [DEPTH];

    rf_scrub_seq #(
        .ADDR_W (ADDR_W)
    ) u_scrub (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr),
        .scrub_we   (scrubWe),
        .scrub_addr (scrubAddr),
        .ready      (ready)
    );

    // A pipeline write lands only in service, loses to a same-cycle clr,
    // and is dropped when it targets the hardwired-zero entry.
    always_comb begin
        userWr = ready && we && !clr;
        if ((ZERO_REG != 0) && (waddr == '0)) begin
            userWr = 1'b0;
        end
    end

    // The scrub sequencer takes over the single write port while active.
    always_comb begin
        memWe    = scrubWe || userWr;
        memAddr  = waddr;
        memWdata = wdata;
        if (scrubWe) begin
            memAddr  = scrubAddr;
            memWdata = '0;
        end
    end

    // Storage is deliberately not reset; the scrub sequencer clears it.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem_q[memAddr] <= memWdata;
        end
    end

    // One registered read port per requested port.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rdAddr;
        logic [DATA_W-1:0] rdata_q;

        assign rdAddr = raddr[k*ADDR_W +: ADDR_W];

        // Priority: scrub forces 0, then the zero entry, then (optionally)
        // forwarding of a same-edge write, then the stored value.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rdata_q <= '0;
            end else if (!ready) begin
                rdata_q <= '0;
            end else if ((ZERO_REG != 0) && (rdAddr == '0)) begin
                rdata_q <= '0;
`ifdef REG_FILE_BYPASS_EN
            end else if (userWr && (rdAddr == waddr)) begin
                rdata_q <= wdata;
`endif
            end else begin
                rdata_q <= mem_q[rdAddr];
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rdata_q;
    end

endmodule : reg_file_mp
